// File: rtl/pspin_feedback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pspin_feedback_pkg
// Description : Shared types and default widths for PsPIN feedback handling.
// Revision    : 1.0 - initial release
// ============================================================================
package pspin_feedback_pkg;

   localparam int c_ADDR_WIDTH   = 32;
   localparam int c_LEN_WIDTH    = 32;
   localparam int c_MSG_ID_WIDTH = 10;

   typedef struct packed {
      logic [c_ADDR_WIDTH-1:0]   her_addr;
      logic [c_LEN_WIDTH-1:0]    her_size;
      logic [c_MSG_ID_WIDTH-1:0] msgid;
   } fb_entry_t;

   // A one-source arbiter still needs a 1-bit pointer to stay legal.
   function automatic int rr_ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pspin_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : pspin_rr_arb
// Description : Round-robin arbiter; pointer moves past the winner on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module pspin_rr_arb
   import pspin_feedback_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant,
   output logic         grant_valid
);

   localparam int c_PTR_W = rr_ptr_width(N);

   logic [c_PTR_W-1:0] r_ptr;
   logic [c_PTR_W-1:0] w_idx;
   logic [c_PTR_W-1:0] w_next_ptr;

   always_comb begin
      int v_idx;
      grant       = '0;
      grant_valid = 1'b0;
      w_idx       = '0;
      v_idx       = 0;
      for (int off = 0; off < N; off++) begin
         v_idx = int'(r_ptr) + off;
         if (v_idx >= N) v_idx = v_idx - N;
         if (!grant_valid && req[v_idx]) begin
            grant_valid  = 1'b1;
            grant[v_idx] = 1'b1;
            w_idx        = c_PTR_W'(v_idx);
         end
      end
   end

   assign w_next_ptr = (w_idx == c_PTR_W'(N-1)) ? '0 : w_idx + 1'b1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ptr <= '0;
      end else if (advance && grant_valid) begin
         r_ptr <= w_next_ptr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pspin_feedback_arb.sv
`default_nettype none
// ============================================================================
// Module      : pspin_feedback_arb
// Description : Merges per-cluster HER feedback into one registered stream and
//               tracks in-flight HERs.
// Revision    : 1.0 - initial release
// ============================================================================
module pspin_feedback_arb
   import pspin_feedback_pkg::*;
#(
   parameter int NUM_CLUSTERS   = 2,
   parameter int ADDR_WIDTH     = c_ADDR_WIDTH,
   parameter int LEN_WIDTH      = c_LEN_WIDTH,
   parameter int MSG_ID_WIDTH   = c_MSG_ID_WIDTH,
   parameter int INFLIGHT_WIDTH = 16,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic [NUM_CLUSTERS-1:0]            s_fb_valid,
   output logic [NUM_CLUSTERS-1:0]            s_fb_ready,
   input  logic [NUM_CLUSTERS*ADDR_WIDTH-1:0] s_fb_her_addr,
   input  logic [NUM_CLUSTERS*LEN_WIDTH-1:0]  s_fb_her_size,
   input  logic [NUM_CLUSTERS*MSG_ID_WIDTH-1:0] s_fb_msgid,
   output logic                               m_fb_valid,
   input  logic                               m_fb_ready,
   output logic [ADDR_WIDTH-1:0]              m_fb_her_addr,
   output logic [LEN_WIDTH-1:0]               m_fb_her_size,
   output logic [MSG_ID_WIDTH-1:0]            m_fb_msgid,
   input  logic                               her_issue,
   output logic [INFLIGHT_WIDTH-1:0]          inflight_count,
   output logic [CNT_WIDTH-1:0]               fb_count,
   output logic                               underflow_err,
   output logic                               overflow_err
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   her_addr;
      logic [LEN_WIDTH-1:0]    her_size;
      logic [MSG_ID_WIDTH-1:0] msgid;
   } entry_t;

   logic [NUM_CLUSTERS-1:0]   w_full;
   logic [NUM_CLUSTERS-1:0]   w_grant;
   logic                      w_grant_valid;
   logic                      w_free;
   logic                      w_load;
   logic                      w_deliver;
   entry_t                    w_slot [NUM_CLUSTERS];
   entry_t                    w_sel;
   entry_t                    r_out;
   logic                      r_valid;
   logic [INFLIGHT_WIDTH-1:0] r_inflight;
   logic [CNT_WIDTH-1:0]      r_fb_count;
   logic                      r_underflow;
   logic                      r_overflow;

   assign w_free     = ~r_valid | m_fb_ready;
   assign w_load     = w_free & w_grant_valid;
   assign w_deliver  = r_valid & m_fb_ready;
   // Ready depends only on slot occupancy, so m_fb_ready never reaches it.
   assign s_fb_ready = ~w_full;

   pspin_rr_arb #(
      .N (NUM_CLUSTERS)
   ) u_rr_arb (
      .clk         (clk),
      .rstn        (rstn),
      .req         (w_full),
      .advance     (w_load),
      .grant       (w_grant),
      .grant_valid (w_grant_valid)
   );

   for (genvar i = 0; i < NUM_CLUSTERS; i++) begin : g_slot
      logic   r_full;
      entry_t r_entry;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_full  <= 1'b0;
            r_entry <= '0;
         end else if (w_load && w_grant[i]) begin
            r_full <= 1'b0;
         end else if (s_fb_valid[i] && !r_full) begin
            r_full           <= 1'b1;
            r_entry.her_addr <= s_fb_her_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            r_entry.her_size <= s_fb_her_size[i*LEN_WIDTH +: LEN_WIDTH];
            r_entry.msgid    <= s_fb_msgid[i*MSG_ID_WIDTH +: MSG_ID_WIDTH];
         end
      end

      assign w_full[i] = r_full;
      assign w_slot[i] = r_entry;
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
         if (w_grant[i]) w_sel = w_slot[i];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_out   <= '0;
      end else if (w_free) begin
         r_valid <= w_grant_valid;
         if (w_grant_valid) r_out <= w_sel;
      end
   end

   // Simultaneous issue and delivery cancel out, even at the limits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_inflight  <= '0;
         r_fb_count  <= '0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_deliver) r_fb_count <= r_fb_count + 1'b1;
         case ({her_issue, w_deliver})
            2'b10: begin
               if (&r_inflight) r_overflow <= 1'b1;
               else             r_inflight <= r_inflight + 1'b1;
            end
            2'b01: begin
               if (r_inflight == '0) r_underflow <= 1'b1;
               else                  r_inflight  <= r_inflight - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign m_fb_valid     = r_valid;
   assign m_fb_her_addr  = r_out.her_addr;
   assign m_fb_her_size  = r_out.her_size;
   assign m_fb_msgid     = r_out.msgid;
   assign inflight_count = r_inflight;
   assign fb_count       = r_fb_count;
   assign underflow_err  = r_underflow;
   assign overflow_err   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pspin_feedback_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pspin_feedback_arb
// Description : Scoreboard bench for pspin_feedback_arb (two clusters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pspin_feedback_arb;

   localparam int NC = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   always #5 clk = ~clk;

   logic        tb_valid [NC];
   logic [31:0] tb_addr  [NC];
   logic [31:0] tb_size  [NC];
   logic [9:0]  tb_id    [NC];

   logic [NC-1:0] s_fb_valid;
   logic [NC-1:0] s_fb_ready;
   logic [63:0]   s_fb_her_addr;
   logic [63:0]   s_fb_her_size;
   logic [19:0]   s_fb_msgid;
   logic          m_fb_valid;
   logic          m_fb_ready;
   logic [31:0]   m_fb_her_addr;
   logic [31:0]   m_fb_her_size;
   logic [9:0]    m_fb_msgid;
   logic          her_issue;
   logic [15:0]   inflight_count;
   logic [31:0]   fb_count;
   logic          underflow_err;
   logic          overflow_err;

   assign s_fb_valid    = {tb_valid[1], tb_valid[0]};
   assign s_fb_her_addr = {tb_addr[1], tb_addr[0]};
   assign s_fb_her_size = {tb_size[1], tb_size[0]};
   assign s_fb_msgid    = {tb_id[1], tb_id[0]};

   pspin_feedback_arb dut (
      .clk            (clk),
      .rstn           (rstn),
      .s_fb_valid     (s_fb_valid),
      .s_fb_ready     (s_fb_ready),
      .s_fb_her_addr  (s_fb_her_addr),
      .s_fb_her_size  (s_fb_her_size),
      .s_fb_msgid     (s_fb_msgid),
      .m_fb_valid     (m_fb_valid),
      .m_fb_ready     (m_fb_ready),
      .m_fb_her_addr  (m_fb_her_addr),
      .m_fb_her_size  (m_fb_her_size),
      .m_fb_msgid     (m_fb_msgid),
      .her_issue      (her_issue),
      .inflight_count (inflight_count),
      .fb_count       (fb_count),
      .underflow_err  (underflow_err),
      .overflow_err   (overflow_err)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] s;
      logic [9:0]  id;
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_fail = 0;
   logic abort = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [9:0] id);
      exp_t e;
      e.a = a; e.s = s; e.id = id;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: compares every delivered beat against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rstn && m_fb_valid && m_fb_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_delivery: got addr 0x%0h with empty queue", m_fb_her_addr);
         end else begin
            e = exp_q.pop_front();
            check("delivery", {m_fb_her_addr, m_fb_her_size, m_fb_msgid}, e);
         end
      end
   end

   task automatic send(input int c, input logic [31:0] a, input logic [31:0] s, input logic [9:0] id);
      int w;
      w = 0;
      if (abort) return;
      tb_valid[c] = 1'b1;
      tb_addr[c]  = a;
      tb_size[c]  = s;
      tb_id[c]    = id;
      forever begin
         @(negedge clk);
         if (abort) begin
            tb_valid[c] = 1'b0;
            return;
         end
         if (s_fb_ready[c]) break;
         w++;
         if (w > 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: cluster %0d never ready", c);
            tb_valid[c] = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      tb_valid[c] = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rstn = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #3 rstn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cnt;
      for (int i = 0; i < NC; i++) begin
         tb_valid[i] = 1'b0; tb_addr[i] = '0; tb_size[i] = '0; tb_id[i] = '0;
      end
      m_fb_ready = 1'b0;
      her_issue  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {s_fb_ready, m_fb_valid, m_fb_her_addr, m_fb_her_size, m_fb_msgid,
                            inflight_count, fb_count, underflow_err, overflow_err},
            {2'b11, 1'b0, 32'h0, 32'h0, 10'h0, 16'h0, 32'h0, 1'b0, 1'b0});
      #2 rstn = 1'b1;

      // Single cluster, minimum latency
      m_fb_ready = 1'b1;
      push(32'h1c10_0040, 32'd64, 10'd5);
      send(0, 32'h1c10_0040, 32'd64, 10'd5);
      @(negedge clk);
      check("t1_latency_t1", m_fb_valid, 1'b0);
      @(negedge clk);
      check("t1_latency_t2", {m_fb_valid, m_fb_her_addr, m_fb_her_size, m_fb_msgid},
            {1'b1, 32'h1c10_0040, 32'd64, 10'd5});
      @(posedge clk);
      #1;
      check("t1_fb_count", fb_count, 32'd1);
      drain();

      // Both clusters streaming, alternating grants
      do_reset();
      for (int k = 0; k < 4; k++) begin
         push(32'hA000_0000 + k, 32'd100 + k, 10'(k));
         push(32'hB000_0000 + k, 32'd200 + k, 10'(16 + k));
      end
      fork
         for (int k = 0; k < 4; k++) send(0, 32'hA000_0000 + k, 32'd100 + k, 10'(k));
         for (int k = 0; k < 4; k++) send(1, 32'hB000_0000 + k, 32'd200 + k, 10'(16 + k));
         begin
            w = 0;
            @(negedge clk);
            while (!m_fb_valid && w < 50) begin
               @(negedge clk);
               w++;
            end
            cnt = 1;
            repeat (7) begin
               @(negedge clk);
               cnt += int'(m_fb_valid);
            end
            check("t2_continuous_valid", cnt, 8);
         end
      join
      drain();

      // Backpressure: outputs hold, both slots fill, nothing lost after release
      @(posedge clk);
      #1 m_fb_ready = 1'b0;
      push(32'hC000_0000, 32'd300, 10'd40);
      push(32'hD000_0000, 32'd400, 10'd50);
      push(32'hC000_0001, 32'd301, 10'd41);
      push(32'hD000_0001, 32'd401, 10'd51);
      fork
         begin
            send(0, 32'hC000_0000, 32'd300, 10'd40);
            send(0, 32'hC000_0001, 32'd301, 10'd41);
         end
         begin
            send(1, 32'hD000_0000, 32'd400, 10'd50);
            send(1, 32'hD000_0001, 32'd401, 10'd51);
         end
         begin
            repeat (4) @(posedge clk);
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               check("t3_hold", {m_fb_valid, m_fb_her_addr, m_fb_her_size, m_fb_msgid, s_fb_ready},
                     {1'b1, 32'hC000_0000, 32'd300, 10'd40, 2'b00});
            end
            @(posedge clk);
            #1 m_fb_ready = 1'b1;
         end
      join
      drain();

      // In-flight accounting
      do_reset();
      her_issue = 1'b1;
      repeat (3) @(posedge clk);
      #1 her_issue = 1'b0;
      check("t4_inflight_3", inflight_count, 16'd3);
      m_fb_ready = 1'b0;
      push(32'h0000_1000, 32'd8, 10'd1);
      send(0, 32'h0000_1000, 32'd8, 10'd1);
      w = 0;
      @(negedge clk);
      while (!m_fb_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      m_fb_ready = 1'b1;
      her_issue  = 1'b1;
      @(posedge clk);
      #1;
      m_fb_ready = 1'b0;
      her_issue  = 1'b0;
      check("t4_issue_and_delivery", {inflight_count, fb_count}, {16'd3, 32'd1});
      m_fb_ready = 1'b1;
      for (int k = 0; k < 3; k++) push(32'h0000_2000 + k, 32'd16, 10'(2 + k));
      for (int k = 0; k < 3; k++) send(0, 32'h0000_2000 + k, 32'd16, 10'(2 + k));
      drain();
      @(posedge clk);
      #1;
      check("t4_inflight_0", {inflight_count, underflow_err, overflow_err, fb_count},
            {16'd0, 1'b0, 1'b0, 32'd4});

      // Underflow is flagged and sticky
      push(32'h0000_3000, 32'd32, 10'd9);
      send(1, 32'h0000_3000, 32'd32, 10'd9);
      drain();
      @(posedge clk);
      #1;
      check("t5_underflow", {inflight_count, underflow_err, fb_count}, {16'd0, 1'b1, 32'd5});
      repeat (3) @(posedge clk);
      #1;
      check("t5_underflow_sticky", underflow_err, 1'b1);

      // Asynchronous reset in the middle of a burst
      for (int k = 0; k < 4; k++) begin
         push(32'hE000_0000 + k, 32'd500 + k, 10'(60 + k));
         push(32'hF000_0000 + k, 32'd600 + k, 10'(70 + k));
      end
      fork
         for (int k = 0; k < 4; k++) send(0, 32'hE000_0000 + k, 32'd500 + k, 10'(60 + k));
         for (int k = 0; k < 4; k++) send(1, 32'hF000_0000 + k, 32'd600 + k, 10'(70 + k));
         begin
            repeat (4) @(posedge clk);
            #3;
            check("t6_valid_before_reset", m_fb_valid, 1'b1);
            rstn  = 1'b0;
            abort = 1'b1;
            exp_q.delete();
            #1;
            check("t6_async_clear", {s_fb_ready, m_fb_valid, m_fb_her_addr, inflight_count,
                                     fb_count, underflow_err, overflow_err},
                  {2'b11, 1'b0, 32'h0, 16'h0, 32'h0, 1'b0, 1'b0});
            @(posedge clk);
            #3 rstn = 1'b1;
         end
      join
      abort = 1'b0;
      @(posedge clk);
      #1;
      check("t6_no_stale_output", {m_fb_valid, s_fb_ready}, {1'b0, 2'b11});
      push(32'h1111_0000, 32'd1, 10'd100);
      push(32'h2222_0000, 32'd2, 10'd200);
      fork
         send(1, 32'h2222_0000, 32'd2, 10'd200);
         send(0, 32'h1111_0000, 32'd1, 10'd100);
      join
      drain();
      @(posedge clk);
      #1;
      check("t6_fb_count_after", fb_count, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
